button_conditioner: RTL and testbench

- Conditions the two raw board push-buttons, single-step and run/step select, into clean signals for the CPU clock generator.
- Synchronises each button to `sys_clk` and debounces it with a qualifying counter.
- Drives `manual_toggle` as a clean level that follows the step button.
- Drives `mode` as a latch that toggles once per qualified press of the mode button.
- Sits directly upstream of the clock generator, between the board pins and its `mode`/`manual_toggle` inputs.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/debouncer.sv | 94 +++++++++
 rtl/button_conditioner.sv | 64 ++++++
 tb/tb_button_conditioner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the push-button conditioning logic.
// Imported by the debouncer and the button_conditioner top.
package cpu_pkg;

    localparam int DBNC_CNT_W = 24;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/debouncer.sv
// One button channel: polarity normalise, 2-flop synchroniser, then a
// qualifying-counter FSM that accepts a press or release only after it is stable.
//
// state        | meaning
// IDLE         | button released and qualified
// PRESS_WAIT   | s2 high, counting towards an accepted press
// PRESSED      | button pressed and qualified
// RELEASE_WAIT | s2 low, counting towards an accepted release
module debouncer
    import cpu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic press,
    output logic accept
);

    localparam logic [DBNC_CNT_W-1:0] CNT_LAST = DBNC_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                  pin_norm;
    logic                  s1;
    logic                  s2;
    btn_state_t            state;
    btn_state_t            state_next;
    logic [DBNC_CNT_W-1:0] cnt;
    logic [DBNC_CNT_W-1:0] cnt_next;

    assign pin_norm = BTN_ACTIVE_LOW ? ~pin : pin;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= pin_norm;
            s2    <= s1;
            state <= state_next;
            cnt   <= cnt_next;
            press <= accept;
        end
    end

    // accept marks the PRESS_WAIT->PRESSED edge one cycle before press shows it
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + DBNC_CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + DBNC_CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/button_conditioner.sv
// Conditions the step and mode push-buttons for the CPU clock generator:
// a clean step level/strobe and a run-mode latch toggled per accepted press.
module button_conditioner
    import cpu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter bit          MODE_RESET      = 1'b0
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic step_btn,
    input  logic mode_btn,
    output logic manual_toggle,
    output logic step_pulse,
    output logic mode
);

    logic step_level;
    logic step_press;
    logic step_accept;
    logic mode_level;
    logic mode_press;
    logic mode_accept;
    logic unused_sigs;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_step_dbnc (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .pin     (step_btn),
        .level   (step_level),
        .press   (step_press),
        .accept  (step_accept)
    );

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_mode_dbnc (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .pin     (mode_btn),
        .level   (mode_level),
        .press   (mode_press),
        .accept  (mode_accept)
    );

    // Toggling on accept keeps the mode flip on the same edge as step_pulse.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            mode <= MODE_RESET;
        end else if (mode_accept) begin
            mode <= ~mode;
        end
    end

    assign manual_toggle = step_level;
    assign step_pulse    = step_press;
    assign unused_sigs   = ^{step_accept, mode_level, mode_press};

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, active-low pins;
// a second instance with MODE_RESET=1 shares the stimulus.
module tb_button_conditioner;

    logic sys_clk;
    logic rst_n;
    logic step_btn;
    logic mode_btn;
    logic manual_toggle0, step_pulse0, mode0;
    logic manual_toggle1, step_pulse1, mode1;

    int checks = 0;
    int errors = 0;

    logic [15:0] bounce = 16'b1111_1111_1100_1000;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_LOW  (1'b1),
        .MODE_RESET      (1'b0)
    ) dut0 (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .step_btn      (step_btn),
        .mode_btn      (mode_btn),
        .manual_toggle (manual_toggle0),
        .step_pulse    (step_pulse0),
        .mode          (mode0)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_LOW  (1'b1),
        .MODE_RESET      (1'b1)
    ) dut1 (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .step_btn      (step_btn),
        .mode_btn      (mode_btn),
        .manual_toggle (manual_toggle1),
        .step_pulse    (step_pulse1),
        .mode          (mode1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        step_btn = 1'b1;
        mode_btn = 1'b1;
        rst_n    = 1'b0;

        // reset
        repeat (3) tick();
        check("rst_toggle", manual_toggle0, 1'b0);
        check("rst_pulse", step_pulse0, 1'b0);
        check("rst_mode0", mode0, 1'b0);
        check("rst_mode1", mode1, 1'b1);
        rst_n = 1'b1;
        repeat (2) tick();

        // clean step press and release
        step_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("press_wait_toggle", manual_toggle0, 1'b0);
            check("press_wait_pulse", step_pulse0, 1'b0);
        end
        tick();
        check("press_toggle", manual_toggle0, 1'b1);
        check("press_pulse", step_pulse0, 1'b1);
        check("press_toggle_i1", manual_toggle1, 1'b1);
        tick();
        check("press_pulse_end", step_pulse0, 1'b0);
        check("press_hold", manual_toggle0, 1'b1);
        repeat (12) tick();
        step_btn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("release_wait_toggle", manual_toggle0, 1'b1);
            check("release_wait_pulse", step_pulse0, 1'b0);
        end
        tick();
        check("release_toggle", manual_toggle0, 1'b0);
        repeat (4) tick();

        // bounce rejection
        for (int i = 0; i < 16; i++) begin
            step_btn = bounce[i];
            tick();
            check("bounce_toggle", manual_toggle0, 1'b0);
            check("bounce_pulse", step_pulse0, 1'b0);
        end
        step_btn = 1'b1;
        repeat (4) tick();

        // mode toggling
        mode_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mode1_wait", mode0, 1'b0);
        end
        tick();
        check("mode1_flip", mode0, 1'b1);
        check("mode1_toggle", manual_toggle0, 1'b0);
        repeat (3) tick();
        mode_btn = 1'b1;
        repeat (10) tick();
        check("mode1_release", mode0, 1'b1);
        mode_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mode2_wait", mode0, 1'b1);
        end
        tick();
        check("mode2_flip", mode0, 1'b0);
        check("mode2_toggle", manual_toggle0, 1'b0);
        check("mode2_pulse", step_pulse0, 1'b0);
        repeat (3) tick();
        mode_btn = 1'b1;
        repeat (10) tick();
        check("mode2_release", mode0, 1'b0);

        // reset while pressed
        step_btn = 1'b0;
        repeat (10) tick();
        check("midrst_pre", manual_toggle0, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midrst_toggle", manual_toggle0, 1'b0);
        check("midrst_pulse", step_pulse0, 1'b0);
        check("midrst_mode0", mode0, 1'b0);
        check("midrst_mode1", mode1, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("requal_wait", manual_toggle0, 1'b0);
            check("requal_wait_pulse", step_pulse0, 1'b0);
        end
        tick();
        check("requal_toggle", manual_toggle0, 1'b1);
        check("requal_pulse", step_pulse0, 1'b1);
        tick();
        check("requal_pulse_end", step_pulse0, 1'b0);
        step_btn = 1'b1;
        repeat (10) tick();
        check("requal_release", manual_toggle0, 1'b0);

        // simultaneous presses
        step_btn = 1'b0;
        mode_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sim_wait_pulse", step_pulse0, 1'b0);
            check("sim_wait_mode", mode0, 1'b0);
        end
        tick();
        check("sim_pulse", step_pulse0, 1'b1);
        check("sim_mode0", mode0, 1'b1);
        check("sim_pulse_i1", step_pulse1, 1'b1);
        check("sim_mode1", mode1, 1'b0);
        tick();
        check("sim_pulse_end", step_pulse0, 1'b0);
        check("sim_mode_hold", mode0, 1'b1);
        step_btn = 1'b1;
        mode_btn = 1'b1;
        repeat (10) tick();
        check("sim_release_toggle", manual_toggle0, 1'b0);
        check("sim_release_mode", mode0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
